// File: rtl/cmd_stp_receiver.sv
// cmd_stp_receiver
//
// Receives one SD-card command response from the serial CMD line. A frame is
// 48 bits (short response) or 136 bits (long response). It is shifted in MSB
// first and kept right-aligned in pad_response. Then the transmission bit,
// the end bit and, optionally, the CRC7 field are checked.
//
// Optional feature: define CMD_CRC_CHECK_EN to build the serial CRC7 checker
// (x^7 + x^3 + 1, seed 0). Without it, no CRC logic is present and crc_error
// is tied low.
//
// Ports
//   sd_clock            in   clock, rising edge
//   reset               in   synchronous active-high reset
//   reset_wrapper       in   synchronous clear from the command controller
//   enable_stp_wrapper  in   level, requests reception of one response
//   long_response       in   0 = 48-bit frame, 1 = 136-bit frame
//                            (sampled when leaving IDLE)
//   cmd_in              in   serial CMD line, already synchronised
//   pad_response        out  [135:0] captured frame, right-aligned
//   reception_complete  out  frame finished or timed out (level)
//   frame_error         out  transmission bit != 0 or end bit != 1
//   crc_error           out  CRC7 mismatch
//   timeout_error       out  no start bit within TIMEOUT_CYCLES
module cmd_stp_receiver #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         reset_wrapper,
  input  logic         enable_stp_wrapper,
  input  logic         long_response,
  input  logic         cmd_in,
  output logic [135:0] pad_response,
  output logic         reception_complete,
  output logic         frame_error,
  output logic         crc_error,
  output logic         timeout_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] LAST_SHORT = 8'd47;
  localparam logic [7:0] LAST_LONG  = 8'd135;

  typedef enum logic [2:0] {IDLE, WAIT_START, RECEIVE, DONE, TIMEOUT} state_t;

  state_t         state;
  state_t         next_state;
  logic           clear;
  logic           enable;
  logic           is_long;
  logic [7:0]     bit_cnt;
  logic [TW-1:0]  timeout_cnt;
  logic           timeout_hit;
  logic [135:0]   frame_next;
  logic           trans_bit;

  assign clear       = reset | reset_wrapper;
  assign enable      = enable_stp_wrapper;
  assign frame_next  = {pad_response[134:0], cmd_in};
  // The counter reaches TIMEOUT_CYCLES on this edge.
  assign timeout_hit = cmd_in && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
  // Index of the transmission bit once the whole frame has been shifted in.
  assign trans_bit   = is_long ? frame_next[134] : frame_next[46];

  assign reception_complete = (state == DONE) || (state == TIMEOUT);

  always_ff @(posedge sd_clock) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (enable) next_state = WAIT_START;
      WAIT_START: begin
        if (!enable)          next_state = IDLE;
        else if (!cmd_in)     next_state = RECEIVE;
        else if (timeout_hit) next_state = TIMEOUT;
      end
      RECEIVE: begin
        if (!enable)             next_state = IDLE;
        else if (bit_cnt == 8'd1) next_state = DONE;
      end
      DONE:       if (!enable) next_state = IDLE;
      TIMEOUT:    if (!enable) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Frame shift register, counters and frame/timeout flags.
  always_ff @(posedge sd_clock) begin
    if (clear) begin
      pad_response  <= '0;
      frame_error   <= 1'b0;
      timeout_error <= 1'b0;
      bit_cnt       <= '0;
      timeout_cnt   <= '0;
      is_long       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            pad_response  <= '0;
            frame_error   <= 1'b0;
            timeout_error <= 1'b0;
            timeout_cnt   <= '0;
            is_long       <= long_response;
          end
        end
        WAIT_START: begin
          if (enable) begin
            if (!cmd_in) begin
              pad_response <= frame_next;
              bit_cnt      <= is_long ? LAST_LONG : LAST_SHORT;
            end else begin
              timeout_cnt <= timeout_cnt + TW'(1);
              if (timeout_hit) timeout_error <= 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (enable) begin
            pad_response <= frame_next;
            bit_cnt      <= bit_cnt - 8'd1;
            if (bit_cnt == 8'd1) frame_error <= trans_bit | ~cmd_in;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CMD_CRC_CHECK_EN
  logic [6:0] crc;
  logic       crc_feed;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], fb} ^ {3'b000, fb, 3'b000};
  endfunction

  // bit_cnt - 1 is the final frame index of the bit sampled on this edge.
  // The covered range starts at index 8 and ends at 47 or 127. The start bit
  // is never fed: a 0 bit into a zero register leaves it at zero.
  assign crc_feed = (bit_cnt >= 8'd9) && (bit_cnt <= (is_long ? 8'd128 : 8'd48));

  always_ff @(posedge sd_clock) begin
    if (clear) begin
      crc       <= '0;
      crc_error <= 1'b0;
    end else if (state == IDLE && enable) begin
      crc       <= '0;
      crc_error <= 1'b0;
    end else if (state == RECEIVE && enable) begin
      if (crc_feed) crc <= crc7_step(crc, cmd_in);
      if (bit_cnt == 8'd1) crc_error <= (crc != frame_next[7:1]);
    end
  end
`else
  assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_stp_receiver.sv
module tb_cmd_stp_receiver;
  localparam int TO = 64;

  logic         sd_clock = 1'b0;
  logic         reset = 1'b1;
  logic         reset_wrapper = 1'b0;
  logic         enable_stp_wrapper = 1'b0;
  logic         long_response = 1'b0;
  logic         cmd_in = 1'b1;
  logic [135:0] pad_response;
  logic         reception_complete;
  logic         frame_error;
  logic         crc_error;
  logic         timeout_error;

  int checks = 0;
  int errors = 0;

`ifdef CMD_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  cmd_stp_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .sd_clock(sd_clock),
    .reset(reset),
    .reset_wrapper(reset_wrapper),
    .enable_stp_wrapper(enable_stp_wrapper),
    .long_response(long_response),
    .cmd_in(cmd_in),
    .pad_response(pad_response),
    .reception_complete(reception_complete),
    .frame_error(frame_error),
    .crc_error(crc_error),
    .timeout_error(timeout_error)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89),
  // where M(x) is the frame bits [hi:8].
  function automatic logic [6:0] model_crc7(input logic [135:0] f, input int hi);
    logic [142:0] d;
    d = '0;
    for (int i = 8; i <= hi; i++) d[i - 1] = f[i];
    for (int i = hi - 1; i >= 7; i--)
      if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
    return d[6:0];
  endfunction

  function automatic logic model_crc_err(input logic [135:0] f, input logic lng);
    if (!CRC_ON) return 1'b0;
    return model_crc7(f, lng ? 127 : 47) != f[7:1];
  endfunction

  function automatic logic model_frame_err(input logic [135:0] f, input logic lng);
    return (lng ? f[134] : f[46]) | ~f[0];
  endfunction

  // Build a random, well-formed frame: start 0, transmission 0, end 1, valid CRC.
  function automatic logic [135:0] make_frame(input logic lng);
    logic [135:0] f;
    int L;
    L = lng ? 136 : 48;
    f = '0;
    for (int i = 8; i <= L - 3; i++) f[i] = 1'($urandom_range(0, 1));
    f[0] = 1'b1;
    f[7:1] = model_crc7(f, lng ? 127 : 47);
    return f;
  endfunction

  // Drives one whole response. lat = edges from the start-bit edge to the
  // first edge after which reception_complete is high (-1 if never).
  task automatic send_response(input logic [135:0] f, input logic lng, input int idle, output int lat);
    int L;
    L = lng ? 136 : 48;
    long_response = lng;
    enable_stp_wrapper = 1'b1;
    cmd_in = 1'b1;
    tick();
    long_response = 1'($urandom_range(0, 1));
    repeat (idle) tick();
    cmd_in = f[L - 1];
    tick();
    lat = -1;
    for (int e = 1; e < L; e++) begin
      cmd_in = f[L - 1 - e];
      tick();
      if (reception_complete && lat < 0) lat = e;
    end
    cmd_in = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_stp_wrapper = 1'b1; cmd_in = 1'b0; long_response = 1'b1;
    repeat (3) tick();
    checks++; if (pad_response !== '0) begin errors++; $display("FAIL reset_pad got %h want 0", pad_response); end
    checks++; if (reception_complete !== 1'b0) begin errors++; $display("FAIL reset_rc got %b want 0", reception_complete); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_error); end
    checks++; if (crc_error !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", crc_error); end
    checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL reset_te got %b want 0", timeout_error); end
    reset = 1'b0; enable_stp_wrapper = 1'b0; cmd_in = 1'b1;
    tick();
  endtask

  task automatic test_short_frame();
    logic [135:0] f;
    int lat;
    f = 136'h110000090067;
    send_response(f, 1'b0, 5, lat);
    checks++; if (pad_response !== f) begin errors++; $display("FAIL short_pad got %h want %h", pad_response, f); end
    checks++; if (lat !== 47) begin errors++; $display("FAIL short_latency got %0d want 47", lat); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL short_fe got %b want 0", frame_error); end
    checks++; if (crc_error !== 1'b0) begin errors++; $display("FAIL short_ce got %b want 0", crc_error); end
    checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL short_te got %b want 0", timeout_error); end
    // DONE ignores cmd_in and holds everything.
    for (int i = 0; i < 6; i++) begin
      cmd_in = 1'($urandom_range(0, 1));
      tick();
    end
    checks++; if (reception_complete !== 1'b1) begin errors++; $display("FAIL done_hold_rc got %b want 1", reception_complete); end
    checks++; if (pad_response !== f) begin errors++; $display("FAIL done_hold_pad got %h want %h", pad_response, f); end
    enable_stp_wrapper = 1'b0;
    tick();
    checks++; if (reception_complete !== 1'b0) begin errors++; $display("FAIL idle_rc got %b want 0", reception_complete); end
    checks++; if (pad_response !== f) begin errors++; $display("FAIL idle_keep_pad got %h want %h", pad_response, f); end
  endtask

  task automatic test_crc_fault();
    logic [135:0] f;
    int lat;
    f = 136'h110000090065;
    send_response(f, 1'b0, 2, lat);
    checks++; if (reception_complete !== 1'b1) begin errors++; $display("FAIL crcfault_rc got %b want 1", reception_complete); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL crcfault_fe got %b want 0", frame_error); end
    checks++; if (crc_error !== CRC_ON) begin errors++; $display("FAIL crcfault_ce got %b want %b", crc_error, CRC_ON); end
    enable_stp_wrapper = 1'b0;
    tick();
    checks++; if (crc_error !== CRC_ON) begin errors++; $display("FAIL crcfault_idle_ce got %b want %b", crc_error, CRC_ON); end
  endtask

  task automatic test_frame_fault();
    logic [135:0] f;
    int lat;
    f = 136'h110000090066;
    send_response(f, 1'b0, 1, lat);
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL endbit_fe got %b want 1", frame_error); end
    checks++; if (crc_error !== 1'b0) begin errors++; $display("FAIL endbit_ce got %b want 0", crc_error); end
    enable_stp_wrapper = 1'b0;
    tick();
    f = 136'h510000090067;
    send_response(f, 1'b0, 3, lat);
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL transbit_fe got %b want 1", frame_error); end
    checks++; if (crc_error !== model_crc_err(f, 1'b0)) begin errors++; $display("FAIL transbit_ce got %b want %b", crc_error, model_crc_err(f, 1'b0)); end
    // Reset wins over an asserted enable while in DONE.
    reset = 1'b1; cmd_in = 1'b0;
    tick();
    checks++; if (pad_response !== '0) begin errors++; $display("FAIL done_reset_pad got %h want 0", pad_response); end
    checks++; if (reception_complete !== 1'b0) begin errors++; $display("FAIL done_reset_rc got %b want 0", reception_complete); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL done_reset_fe got %b want 0", frame_error); end
    reset = 1'b0; enable_stp_wrapper = 1'b0; cmd_in = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int edges;
    long_response = 1'b0; enable_stp_wrapper = 1'b1; cmd_in = 1'b1;
    tick();
    edges = 0;
    while (!reception_complete && edges < 3 * TO) begin
      tick();
      edges++;
    end
    checks++; if (edges !== TO) begin errors++; $display("FAIL timeout_edges got %0d want %0d", edges, TO); end
    checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL timeout_te got %b want 1", timeout_error); end
    checks++; if (pad_response !== '0) begin errors++; $display("FAIL timeout_pad got %h want 0", pad_response); end
    for (int i = 0; i < 5; i++) begin
      cmd_in = 1'($urandom_range(0, 1));
      tick();
    end
    checks++; if (reception_complete !== 1'b1) begin errors++; $display("FAIL timeout_hold_rc got %b want 1", reception_complete); end
    checks++; if (pad_response !== '0) begin errors++; $display("FAIL timeout_hold_pad got %h want 0", pad_response); end
    enable_stp_wrapper = 1'b0;
    tick();
    checks++; if (reception_complete !== 1'b0) begin errors++; $display("FAIL timeout_idle_rc got %b want 0", reception_complete); end
    checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL timeout_idle_te got %b want 1", timeout_error); end
  endtask

  task automatic test_long_frame();
    logic [135:0] f;
    logic [119:0] cid;
    int lat;
    cid = {$urandom(), $urandom(), $urandom(), $urandom()} >> 8;
    f = {8'h3F, cid, model_crc7({8'h3F, cid, 8'h00}, 127), 1'b1};
    send_response(f, 1'b1, 4, lat);
    checks++; if (pad_response !== f) begin errors++; $display("FAIL long_pad got %h want %h", pad_response, f); end
    checks++; if (lat !== 135) begin errors++; $display("FAIL long_latency got %0d want 135", lat); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL long_fe got %b want 0", frame_error); end
    checks++; if (crc_error !== 1'b0) begin errors++; $display("FAIL long_ce got %b want 0", crc_error); end
    enable_stp_wrapper = 1'b0;
    tick();
  endtask

  task automatic test_random_frames();
    logic [135:0] f;
    logic lng;
    int L;
    int lat;
    int pick;
    for (int n = 0; n < 10; n++) begin
      lng = 1'($urandom_range(0, 1));
      L = lng ? 136 : 48;
      f = make_frame(lng);
      pick = $urandom_range(0, 3);
      if (pick == 1) f[0] = 1'b0;
      if (pick == 2) f[L - 2] = 1'b1;
      if (pick == 3) f[$urandom_range(1, 7)] ^= 1'b1;
      send_response(f, lng, $urandom_range(0, 20), lat);
      checks++; if (pad_response !== f) begin errors++; $display("FAIL rand%0d_pad got %h want %h", n, pad_response, f); end
      checks++; if (lat !== L - 1) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, L - 1); end
      checks++; if (frame_error !== model_frame_err(f, lng)) begin errors++; $display("FAIL rand%0d_fe got %b want %b", n, frame_error, model_frame_err(f, lng)); end
      checks++; if (crc_error !== model_crc_err(f, lng)) begin errors++; $display("FAIL rand%0d_ce got %b want %b", n, crc_error, model_crc_err(f, lng)); end
      enable_stp_wrapper = 1'b0;
      tick();
    end
  endtask

  task automatic test_abort_reset_wrapper();
    long_response = 1'b0; enable_stp_wrapper = 1'b1; cmd_in = 1'b1;
    tick();
    cmd_in = 1'b0;
    tick();
    for (int i = 1; i < 20; i++) begin
      cmd_in = 1'b1;
      tick();
    end
    reset_wrapper = 1'b1; cmd_in = 1'b1;
    tick();
    checks++; if (pad_response !== '0) begin errors++; $display("FAIL rw_abort_pad got %h want 0", pad_response); end
    checks++; if (reception_complete !== 1'b0) begin errors++; $display("FAIL rw_abort_rc got %b want 0", reception_complete); end
    checks++; if ({frame_error, crc_error, timeout_error} !== 3'b000) begin errors++; $display("FAIL rw_abort_flags got %b want 000", {frame_error, crc_error, timeout_error}); end
    reset_wrapper = 1'b0; enable_stp_wrapper = 1'b0;
    tick();
  endtask

  task automatic test_abort_enable();
    logic [135:0] f;
    int rc_seen;
    int lat;
    rc_seen = 0;
    long_response = 1'b1; enable_stp_wrapper = 1'b1; cmd_in = 1'b1;
    tick();
    cmd_in = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) begin
      cmd_in = 1'($urandom_range(0, 1));
      tick();
      if (reception_complete) rc_seen++;
    end
    enable_stp_wrapper = 1'b0;
    for (int i = 0; i < 150; i++) begin
      cmd_in = 1'($urandom_range(0, 1));
      tick();
      if (reception_complete) rc_seen++;
    end
    checks++; if (rc_seen !== 0) begin errors++; $display("FAIL en_abort_rc got %0d high cycles want 0", rc_seen); end
    f = make_frame(1'b0);
    send_response(f, 1'b0, 2, lat);
    checks++; if (pad_response !== f) begin errors++; $display("FAIL after_abort_pad got %h want %h", pad_response, f); end
    checks++; if (lat !== 47) begin errors++; $display("FAIL after_abort_latency got %0d want 47", lat); end
    enable_stp_wrapper = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_crc_fault();
    test_frame_fault();
    test_timeout();
    test_long_frame();
    test_random_frames();
    test_abort_reset_wrapper();
    test_abort_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_stp_receiver.md
CMD_STP_RECEIVER -- requirements
Module: cmd_stp_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of sd_clock cycles to wait for a start bit.
REQ-002 SHALL have the port sd_clock, input, 1, the clock; every flop samples on the rising edge.
REQ-003 SHALL have the port reset, input, 1, the synchronous, active-high reset.
REQ-004 SHALL have the port reset_wrapper, input, 1, a synchronous clear from the command controller with the same effect as reset.
REQ-005 SHALL have the port enable_stp_wrapper, input, 1, a level that requests reception of one response.
REQ-006 SHALL have the port long_response, input, 1, selecting the frame length: 0 = 48-bit, 1 = 136-bit; sampled on the WAIT_START entry edge.
REQ-007 SHALL have the port cmd_in, input, 1, the serial CMD line, already synchronised.
REQ-008 SHALL have the port pad_response, output, 136, the captured frame, MSB first, right-aligned (a 48-bit frame occupies [47:0], start bit at [47]).
REQ-009 SHALL have the port reception_complete, output, 1, a level meaning the frame is done or has timed out.
REQ-010 SHALL have the port frame_error, output, 1, flagging a transmission bit not equal to 0 or an end bit not equal to 1.
REQ-011 SHALL have the port crc_error, output, 1, flagging a CRC7 mismatch.
REQ-012 SHALL have the port timeout_error, output, 1, flagging that no start bit was seen within TIMEOUT_CYCLES.

Function
REQ-013 SHALL implement the states IDLE, WAIT_START, RECEIVE, DONE and TIMEOUT.
REQ-014 SHALL move IDLE->WAIT_START on the first edge with enable_stp_wrapper=1, clearing pad_response, all error flags and the timeout counter on that edge.
REQ-015 SHALL, in WAIT_START, increment the timeout counter on each edge with cmd_in=1.
REQ-016 SHALL, in WAIT_START, on the edge sampling cmd_in=0, shift 0 into pad_response, load bit counter L-1 (L = 48 or 136) and go to RECEIVE.
REQ-017 SHALL, in WAIT_START, on the edge where the counter reaches TIMEOUT_CYCLES with no start bit, go to TIMEOUT.
REQ-018 SHALL, in RECEIVE, shift cmd_in into the LSB of the frame each edge and decrement the bit counter.
REQ-019 SHALL, in RECEIVE, on the edge sampling the end bit (counter = 1), go to DONE and register frame_error and crc_error on that same edge.
REQ-020 SHALL set frame_error = (transmission bit != 0) | (end bit != 1), where the transmission bit is [46] for L=48 and [134] for L=136.
REQ-021 SHALL, in DONE, hold reception_complete=1 and hold pad_response and the error flags stable.
REQ-022 SHALL, in TIMEOUT, hold reception_complete=1, timeout_error=1 and pad_response=0.
REQ-023 SHALL leave DONE or TIMEOUT for IDLE only when enable_stp_wrapper=0.
REQ-024 SHALL keep pad_response and the error flags in IDLE until the next WAIT_START entry or a reset; the controller reads them after dropping enable.
REQ-025 SHALL abort RECEIVE to IDLE when enable_stp_wrapper=0, leaving reception_complete=0 and the partial frame contents unspecified.
REQ-026 SHALL give reset and reset_wrapper priority over every transition when either is asserted together with any other input.
REQ-027 SHALL ignore cmd_in in IDLE, DONE and TIMEOUT.
REQ-028 SHALL produce reception_complete high starting L-1 edges after the start-bit edge (latency L-1).

Reset
REQ-029 SHALL, when reset or reset_wrapper is 1 at an edge, set state=IDLE, pad_response=0, reception_complete=0, frame_error=0, crc_error=0, timeout_error=0, bit counter=0 and timeout counter=0.

Configuration
REQ-030 SHALL, with CMD_CRC_CHECK_EN defined, compute a serial CRC7 (polynomial x^7+x^3+1, initial value 0).
REQ-031 SHALL, with CMD_CRC_CHECK_EN defined, feed the CRC over frame bits [47:8] for L=48 and [127:8] for L=136, compare it to bits [7:1] and set crc_error on mismatch.
REQ-032 SHALL, without CMD_CRC_CHECK_EN, contain no CRC logic and tie crc_error to 0.

Verification
REQ-033 SHALL cover a short frame: L=48 frame 0x11_00000900_67 (CRC 0x33) after 5 idle cycles -> pad_response[47:0]=0x110000090067, reception_complete 47 edges after start, no error flags.
REQ-034 SHALL cover a CRC fault (CMD_CRC_CHECK_EN defined): same frame with last byte 0x65 -> crc_error=1, frame_error=0, reception_complete=1.
REQ-035 SHALL cover a frame fault: short frame with end bit 0 -> frame_error=1; with the transmission bit 1 -> frame_error=1.
REQ-036 SHALL cover a timeout: enable=1 and cmd_in held 1 for 64 cycles -> timeout_error=1, reception_complete=1, pad_response=0; enable=0 -> IDLE.
REQ-037 SHALL cover a long frame: L=136 random CID with valid CRC -> pad_response matches bit-exact, completion 135 edges after start.
REQ-038 SHALL cover abort paths: reset_wrapper pulse at bit 20 -> all outputs 0 next edge; enable drop mid-RECEIVE -> IDLE with reception_complete never asserted.
